// File: rtl/hwpe_ctrl_regfile_mp.sv
// rtl/hwpe_ctrl_regfile_mp.sv - multi-read-port FF register file with staged writes and forwarding
// Optional byte parity: define HWPE_CTRL_REGFILE_PARITY_EN.
module hwpe_ctrl_regfile_mp #(
    parameter int unsigned NUM_WORDS  = 24,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned NUM_BYTE   = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear,
    input  logic                             we_i,
    input  logic [ADDR_WIDTH-1:0]            waddr_i,
    input  logic [DATA_WIDTH-1:0]            wdata_i,
    input  logic [NUM_BYTE-1:0]              wbe_i,
    input  logic [NUM_RPORTS-1:0]            re_i,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rvalid_o,
    output logic                             addr_err_o,
    output logic [NUM_RPORTS-1:0]            parity_err_o,
    output logic [NUM_WORDS*DATA_WIDTH-1:0]  mem_content_o
);

    localparam logic [ADDR_WIDTH:0] NW = NUM_WORDS[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0]            mem_q [NUM_WORDS];
    logic                             stg_valid_q, stg_valid_d;
    logic [ADDR_WIDTH-1:0]            stg_addr_q;
    logic [DATA_WIDTH-1:0]            stg_data_q;
    logic [NUM_BYTE-1:0]              stg_be_q;
    logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_q;
    logic [NUM_RPORTS-1:0]            rvalid_q;
    logic                             addr_err_q, addr_err_d;

    logic                             w_inr;
    logic [ADDR_WIDTH-1:0]            raddr   [NUM_RPORTS];
    logic [NUM_RPORTS-1:0]            rd_inr;
    logic [DATA_WIDTH-1:0]            rd_word [NUM_RPORTS];

    assign w_inr       = ({1'b0, waddr_i} < NW);
    assign stg_valid_d = we_i && w_inr && !clear;

    always_comb begin
        addr_err_d = we_i && !w_inr;
        rd_inr     = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            raddr[p]   = raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
            rd_inr[p]  = ({1'b0, raddr[p]} < NW);
            rd_word[p] = '0;
            if (rd_inr[p]) begin
                rd_word[p] = mem_q[raddr[p]];
                // forward bytes of the not-yet-committed staged write
                for (int b = 0; b < NUM_BYTE; b++) begin
                    if (stg_valid_q && stg_addr_q == raddr[p] && stg_be_q[b])
                        rd_word[p][b*8 +: 8] = stg_data_q[b*8 +: 8];
                end
            end
            if (re_i[p] && !rd_inr[p])
                addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_q <= 1'b0;
            stg_addr_q  <= '0;
            stg_data_q  <= '0;
            stg_be_q    <= '0;
        end else begin
            stg_valid_q <= stg_valid_d;
            if (clear) begin
                stg_addr_q <= '0;
                stg_data_q <= '0;
                stg_be_q   <= '0;
            end else if (stg_valid_d) begin
                stg_addr_q <= waddr_i;
                stg_data_q <= wdata_i;
                stg_be_q   <= wbe_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WORDS; w++)
                mem_q[w] <= '0;
        end else if (clear) begin
            for (int w = 0; w < NUM_WORDS; w++)
                mem_q[w] <= '0;
        end else if (stg_valid_q) begin
            for (int b = 0; b < NUM_BYTE; b++) begin
                if (stg_be_q[b])
                    mem_q[stg_addr_q][b*8 +: 8] <= stg_data_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            rvalid_q   <= '0;
            addr_err_q <= 1'b0;
        end else begin
            rvalid_q   <= re_i;
            addr_err_q <= addr_err_d;
            for (int p = 0; p < NUM_RPORTS; p++) begin
                if (re_i[p])
                    rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
            end
        end
    end

`ifdef HWPE_CTRL_REGFILE_PARITY_EN
    logic [NUM_BYTE-1:0]   par_q [NUM_WORDS];
    logic [NUM_BYTE-1:0]   stg_par_q;
    logic [NUM_BYTE-1:0]   wpar;
    logic [NUM_BYTE-1:0]   rd_par [NUM_RPORTS];
    logic [NUM_RPORTS-1:0] par_mis;
    logic [NUM_RPORTS-1:0] par_err_q;

    always_comb begin
        for (int b = 0; b < NUM_BYTE; b++)
            wpar[b] = ^wdata_i[b*8 +: 8];
        par_mis = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd_par[p] = '0;
            if (rd_inr[p]) begin
                rd_par[p] = par_q[raddr[p]];
                for (int b = 0; b < NUM_BYTE; b++) begin
                    if (stg_valid_q && stg_addr_q == raddr[p] && stg_be_q[b])
                        rd_par[p][b] = stg_par_q[b];
                end
            end
            for (int b = 0; b < NUM_BYTE; b++) begin
                if (rd_par[p][b] != ^rd_word[p][b*8 +: 8])
                    par_mis[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_par_q <= '0;
            par_err_q <= '0;
            for (int w = 0; w < NUM_WORDS; w++)
                par_q[w] <= '0;
        end else begin
            par_err_q <= re_i & par_mis;
            if (clear) begin
                stg_par_q <= '0;
                for (int w = 0; w < NUM_WORDS; w++)
                    par_q[w] <= '0;
            end else begin
                if (stg_valid_d)
                    stg_par_q <= wpar;
                if (stg_valid_q) begin
                    for (int b = 0; b < NUM_BYTE; b++) begin
                        if (stg_be_q[b])
                            par_q[stg_addr_q][b] <= stg_par_q[b];
                    end
                end
            end
        end
    end

    assign parity_err_o = par_err_q;
`else
    assign parity_err_o = '0;
`endif

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_content
        assign mem_content_o[w*DATA_WIDTH +: DATA_WIDTH] = mem_q[w];
    end

    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign addr_err_o = addr_err_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_mp.sv
// tb/tb_hwpe_ctrl_regfile_mp.sv - scoreboard testbench for hwpe_ctrl_regfile_mp
module tb_hwpe_ctrl_regfile_mp;

    localparam int NW = 24;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int NB = 4;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            rst_n, clear, we;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [NB-1:0]   wbe;
    logic [NP-1:0]   re;
    logic [NP*AW-1:0] raddr;
    logic [NP*DW-1:0] rdata;
    logic [NP-1:0]   rvalid, parity_err;
    logic            addr_err;
    logic [NW*DW-1:0] mem_content;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] model [NW];
    logic [DW-1:0] exp_q [NP][$];
    logic          exp_err;

    always #5 clk = ~clk;

    hwpe_ctrl_regfile_mp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear         (clear),
        .we_i          (we),
        .waddr_i       (waddr),
        .wdata_i       (wdata),
        .wbe_i         (wbe),
        .re_i          (re),
        .raddr_i       (raddr),
        .rdata_o       (rdata),
        .rvalid_o      (rvalid),
        .addr_err_o    (addr_err),
        .parity_err_o  (parity_err),
        .mem_content_o (mem_content)
    );

    // scoreboard: every rvalid pops the expectation pushed when the read was issued
    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < NP; p++) begin
                if (rvalid[p]) begin
                    logic [DW-1:0] e;
                    n_tests++;
                    if (exp_q[p].size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_rvalid%0d: unexpected rvalid, rdata=%h", p, rdata[p*DW +: DW]);
                    end else begin
                        e = exp_q[p].pop_front();
                        if (rdata[p*DW +: DW] !== e) begin
                            n_fail++;
                            $display("FAIL sb_rdata%0d: got %h expected %h", p, rdata[p*DW +: DW], e);
                        end
                    end
                end
            end
        end
    end

    task automatic model_zero();
        for (int w = 0; w < NW; w++) model[w] = '0;
    endtask

    task automatic step();
        logic [AW-1:0] a;
        exp_err = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (re[p]) begin
                a = raddr[p*AW +: AW];
                if (a < NW) exp_q[p].push_back(model[a]);
                else begin
                    exp_q[p].push_back('0);
                    exp_err = 1'b1;
                end
            end
        end
        if (we && waddr >= NW) exp_err = 1'b1;
        if (clear) model_zero();
        else if (we && waddr < NW) begin
            for (int b = 0; b < NB; b++)
                if (wbe[b]) model[waddr][b*8 +: 8] = wdata[b*8 +: 8];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 0; re = '0; clear = 0;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] be);
        we = 1; waddr = a; wdata = d; wbe = be; re = '0; clear = 0;
        step();
    endtask

    task automatic check_content(input string tag);
        for (int w = 0; w < NW; w++) begin
            n_tests++;
            if (mem_content[w*DW +: DW] !== model[w]) begin
                n_fail++;
                $display("FAIL %s word%0d: got %h expected %h", tag, w, mem_content[w*DW +: DW], model[w]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; clear = 0; we = 0; waddr = '0; wdata = '0; wbe = '0; re = '0; raddr = '0;
        model_zero();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({rdata, rvalid, addr_err, parity_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h rvalid=%b err=%b perr=%b required all 0", rdata, rvalid, addr_err, parity_err);
        end
        check_content("reset_content");
        rst_n = 1;
        idle();
        re = 2'b11; raddr = {5'd5, 5'd5};
        step();
        n_tests++;
        if (rvalid !== 2'b11 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_read: rvalid=%b err=%b required 11/0", rvalid, addr_err);
        end
        idle();
    endtask

    task automatic test_forwarding();
        wr(5'd3, 32'hDEADBEEF, 4'hF);
        n_tests++;
        if (mem_content[3*DW +: DW] !== 32'h0) begin
            n_fail++;
            $display("FAIL fwd_early_commit: word3=%h required 0", mem_content[3*DW +: DW]);
        end
        we = 0; re = 2'b01; raddr = {5'd0, 5'd3};
        step();
        n_tests++;
        if (mem_content[3*DW +: DW] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fwd_commit: word3=%h required deadbeef", mem_content[3*DW +: DW]);
        end
        idle();
    endtask

    task automatic test_byte_enable();
        wr(5'd7, 32'h11223344, 4'hF);
        wr(5'd7, 32'hAABBCCDD, 4'b0101);
        we = 0; re = 2'b10; raddr = {5'd7, 5'd0};
        step();
        n_tests++;
        if (rdata[DW +: DW] !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL byte_enable: got %h required 11bb33dd", rdata[DW +: DW]);
        end
        wr(5'd7, 32'hFFFFFFFF, 4'h0);
        idle();
        idle();
        check_content("be_zero_content");
    endtask

    task automatic test_clear();
        clear = 1; we = 1; waddr = 5'd2; wdata = 32'h55; wbe = 4'hF;
        re = 2'b01; raddr = {5'd0, 5'd3};
        step();
        n_tests++;
        if (rdata[DW-1:0] !== 32'hDEADBEEF || mem_content[3*DW +: DW] !== 32'h0) begin
            n_fail++;
            $display("FAIL clear_read: rdata0=%h word3=%h required deadbeef/0", rdata[DW-1:0], mem_content[3*DW +: DW]);
        end
        clear = 0; we = 0; re = 2'b11; raddr = {5'd3, 5'd2};
        step();
        idle();
        check_content("clear_content");
    endtask

    task automatic test_out_of_range();
        we = 1; waddr = 5'd30; wdata = 32'h12345678; wbe = 4'hF;
        re = 2'b10; raddr = {5'd25, 5'd0};
        step();
        n_tests++;
        if (addr_err !== 1'b1 || exp_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_pulse: addr_err=%b required 1", addr_err);
        end
        idle();
        n_tests++;
        if (addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_single: addr_err=%b required 0", addr_err);
        end
        idle();
        check_content("oor_content");
    endtask

    task automatic test_reset_mid_write();
        wr(5'd9, 32'hA5A5_0F0F, 4'hF);
        we = 1; waddr = 5'd6; wdata = 32'hCAFEF00D; wbe = 4'hF; re = 2'b01; raddr = {5'd0, 5'd9};
        step();
        we = 0; re = '0;
        #1 rst_n = 0;
        #1;
        n_tests++;
        if ({rdata, rvalid, addr_err, parity_err} !== '0 || mem_content !== '0) begin
            n_fail++;
            $display("FAIL reset_async: rdata=%h rvalid=%b err=%b required 0", rdata, rvalid, addr_err);
        end
        for (int p = 0; p < NP; p++) exp_q[p].delete();
        model_zero();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        idle();
        idle();
        check_content("reset_no_commit");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 60; i++) begin
            we = 1;
            waddr = 5'($urandom_range(0, NW - 1));
            wdata = $urandom;
            wbe = 4'($urandom);
            clear = 0;
            re = 2'($urandom);
            raddr[AW-1:0] = 5'($urandom_range(0, NW - 1));
            raddr[2*AW-1:AW] = (i % 3 == 0) ? raddr[AW-1:0] : 5'($urandom_range(0, NW - 1));
            if (i % 4 == 0) raddr[AW-1:0] = waddr;
            step();
            n_tests++;
            if (addr_err !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_err cycle %0d: addr_err=%b required 0", i, addr_err);
            end
        end
        idle();
        idle();
        check_content("b2b_content");
    endtask

`ifdef HWPE_CTRL_REGFILE_PARITY_EN
    task automatic test_parity();
        wr(5'd4, 32'h0F0F_3C3C, 4'hF);
        wr(5'd3, 32'hDEADBEEF, 4'hF);
        idle();
        idle();
        dut.mem_q[4][9] = ~dut.mem_q[4][9];
        model[4][9] = ~model[4][9];
        re = 2'b01; raddr = {5'd0, 5'd4};
        step();
        n_tests++;
        if (parity_err[0] !== 1'b1 || rvalid[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_detect: perr=%b rvalid=%b required 1/1", parity_err[0], rvalid[0]);
        end
        re = 2'b01; raddr = {5'd0, 5'd3};
        step();
        n_tests++;
        if (parity_err[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_clean: perr=%b required 0", parity_err[0]);
        end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_forwarding();
        test_byte_enable();
        test_clear();
        test_out_of_range();
        test_reset_mid_write();
        test_back_to_back();
`ifdef HWPE_CTRL_REGFILE_PARITY_EN
        test_parity();
`endif
        idle();
        for (int p = 0; p < NP; p++) begin
            n_tests++;
            if (exp_q[p].size() != 0) begin
                n_fail++;
                $display("FAIL sb_drain%0d: %0d reads never returned, required 0", p, exp_q[p].size());
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
